// File: rtl/if_unit_pkg.sv
// Shared widths, default constants and FSM encoding for the instruction-fetch stage.
package if_unit_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [DATA_W-1:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/if_unit_if.sv
// Fetch-stage bus: ROM address/data, execute redirect and stall, and the IF/ID outputs to decode.
interface if_unit_if;
    import if_unit_pkg::*;

    logic [ADDR_W-1:0] inst_addr_o;
    logic [DATA_W-1:0] inst_i;
    logic              hold_i;
    logic              jump_en_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_id_o;
    logic              inst_valid_o;
    logic              misalign_err_o;

    modport master (
        output inst_addr_o, inst_o, inst_addr_id_o, inst_valid_o, misalign_err_o,
        input  inst_i, hold_i, jump_en_i, jump_addr_i
    );

    modport slave (
        input  inst_addr_o, inst_o, inst_addr_id_o, inst_valid_o, misalign_err_o,
        output inst_i, hold_i, jump_en_i, jump_addr_i
    );
endinterface

// File: rtl/if_unit_if_id.sv
// IF/ID pipeline register: flush inserts a bubble but keeps the last PC, capture loads a fetched word.
module if_id
    import if_unit_pkg::*;
#(
    parameter logic [DATA_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic              flush,
    input  logic [DATA_W-1:0] inst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] inst_q,
    output logic [ADDR_W-1:0] addr_q,
    output logic              valid_q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q  <= NOP_INST;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (cap_en) begin
            inst_q  <= inst;
            addr_q  <= addr;
            valid_q <= 1'b1;
        end
    end
endmodule

// File: rtl/if_unit.sv
// Instruction-fetch stage: PC register, boot-delay FSM, redirect/stall control and misalignment flag.
module if_unit
    import if_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [DATA_W-1:0] NOP_INST   = NOP_INST_DEF,
    parameter int                BOOT_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst,
    if_unit_if.master  bus
);
    localparam int CNT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0);
    // With no boot delay the FSM leaves reset already running.
    localparam state_e RST_STATE = (BOOT_DELAY == 0) ? RUN : BOOT;
    localparam logic [ADDR_W-1:0] RESET_PC_AL = {RESET_PC[ADDR_W-1:2], 2'b00};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] pc_q;
    logic              err_q;
    logic              run, jump, cap;

    always_ff @(posedge clk) begin
        if (rst) state_q <= RST_STATE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    if (cnt_q == CNT_LAST) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    assign run  = (state_q == RUN);
    assign jump = run && bus.jump_en_i;
    assign cap  = run && !bus.jump_en_i && !bus.hold_i;

    always_ff @(posedge clk) begin
        if (rst)                 cnt_q <= '0;
        else if (state_q == BOOT) cnt_q <= cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)       pc_q <= RESET_PC_AL;
        else if (jump) pc_q <= {bus.jump_addr_i[ADDR_W-1:2], 2'b00};
        else if (cap)  pc_q <= pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst)                                err_q <= 1'b0;
        else if (jump && |bus.jump_addr_i[1:0]) err_q <= 1'b1;
    end

    assign bus.inst_addr_o    = pc_q;
    assign bus.misalign_err_o = err_q;

    if_id #(.NOP_INST(NOP_INST)) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .cap_en  (cap),
        .flush   (jump),
        .inst    (bus.inst_i),
        .addr    (pc_q),
        .inst_q  (bus.inst_o),
        .addr_q  (bus.inst_addr_id_o),
        .valid_q (bus.inst_valid_o)
    );
endmodule
